inst_fetch_buf: RTL

- Instruction queue between the fetch stage and the decode stage.
- Accepts fetched instruction/PC pairs from fetch over a level-request / pulse-acknowledge write handshake.
- Reports full back to fetch.
- Presents entries in order to decode over a valid/ready interface.
- Flushed on a control-flow redirect (purge).

---
 rtl/inst_fetch_buf_if.sv | 30 +++
 rtl/inst_fetch_buf.sv | 95 +++++++++
 2 files changed

// File: rtl/inst_fetch_buf_if.sv
// Fetch/decode-side bus of the instruction fetch buffer.
// The buffer takes the slave view; the fetch and decode environment takes the master view.
interface inst_fetch_buf_if #(
    parameter int INST_L = 32,
    parameter int PC_L   = 32,
    parameter int PTR_L  = 2
);
    logic              buf_we;
    logic [INST_L-1:0] inst_in;
    logic [PC_L-1:0]   pc_in;
    logic              buf_wack;
    logic              buf_f;
    logic              buf_e;
    logic              purge;
    logic              dec_valid;
    logic [INST_L-1:0] dec_inst;
    logic [PC_L-1:0]   dec_pc;
    logic              dec_ready;
    logic [PTR_L:0]    count;

    modport slave (
        input  buf_we, inst_in, pc_in, purge, dec_ready,
        output buf_wack, buf_f, buf_e, dec_valid, dec_inst, dec_pc, count
    );

    modport master (
        output buf_we, inst_in, pc_in, purge, dec_ready,
        input  buf_wack, buf_f, buf_e, dec_valid, dec_inst, dec_pc, count
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// Instruction queue between fetch and decode: edge-armed write handshake in,
// valid/ready out, flushed by purge on a control-flow redirect.
module inst_fetch_buf #(
    parameter int INST_L = 32,
    parameter int PC_L   = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_L  = 2
) (
    input logic            clk,
    input logic            rst_n,
    inst_fetch_buf_if.slave bus
);

    localparam logic [PTR_L:0] FULL_CNT = (PTR_L + 1)'(DEPTH);

    logic [INST_L-1:0] r_inst_mem [DEPTH];
    logic [PC_L-1:0]   r_pc_mem   [DEPTH];
    logic [PTR_L-1:0]  r_wp;
    logic [PTR_L-1:0]  r_rp;
    logic [PTR_L:0]    r_count;
    logic              r_wack;
    logic              r_armed;

    logic              w_valid;
    logic              w_full;
    logic              w_accept;
    logic              w_pop;
    logic [PTR_L:0]    w_inc;
    logic [PTR_L:0]    w_dec;

    // Full blocks acceptance even when a pop frees a slot in the same cycle.
    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_accept = bus.buf_we & r_armed & ~w_full;
    assign w_pop    = w_valid & bus.dec_ready;
    assign w_inc    = (PTR_L + 1)'(w_accept);
    assign w_dec    = (PTR_L + 1)'(w_pop);

    // A purge still completes the fetch handshake: wack pulses and armed clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wack  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_wack <= w_accept;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!bus.buf_we) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (bus.purge) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_count <= r_count + w_inc - w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else if (w_accept && !bus.purge) begin
            r_inst_mem[r_wp] <= bus.inst_in;
            r_pc_mem[r_wp]   <= bus.pc_in;
        end
    end

    // Head is forced to zero when empty so stale storage never leaks after a purge.
    assign bus.dec_valid = w_valid;
    assign bus.dec_inst  = w_valid ? r_inst_mem[r_rp] : '0;
    assign bus.dec_pc    = w_valid ? r_pc_mem[r_rp] : '0;
    assign bus.buf_wack  = r_wack;
    assign bus.buf_f     = w_full;
    assign bus.buf_e     = ~w_valid;
    assign bus.count     = r_count;

endmodule
